// File: rtl/car_mode_ctrl.sv
// car_mode_ctrl: remote-commanded car mode FSM with debounced obstacle alarm and line steering.
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   obstacle   raw obstacle sensor, high = obstacle present (asynchronous)
//   track_l/r  raw line-tracking sensors, high = line seen (asynchronous)
//   cmd_valid  one-cycle command strobe
//   cmd        00 stop, 01 start, 10/11 ignored
//   cs         registered car state: 000 stop, 001 forward, 010 alarm, 011 left, 100 right
module car_mode_ctrl #(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       obstacle,
    input  logic       track_l,
    input  logic       track_r,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic [2:0] cs
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [2:0] CS_STOP  = 3'b000;
    localparam logic [2:0] CS_FWD   = 3'b001;
    localparam logic [2:0] CS_ALARM = 3'b010;
    localparam logic [2:0] CS_LEFT  = 3'b011;
    localparam logic [2:0] CS_RIGHT = 3'b100;

    typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            obs_db_q, obs_db_d;
    logic [2:0]      cs_q, cs_d;
    logic            obs_s, tl_s, tr_s, start, stop;

    assign {obs_s, tl_s, tr_s} = sync2_q;
    assign start = cmd_valid && (cmd == 2'b01);
    assign stop  = cmd_valid && (cmd == 2'b00);
    assign cs    = cs_q;

    always_comb begin
        sync1_d  = {obstacle, track_l, track_r};
        sync2_d  = sync1_q;
        deb_d    = '0;
        obs_db_d = obs_db_q;
        // The counter only reaches DEB_LAST before flipping, so it can never wrap.
        if (obs_s != obs_db_q) begin
            if (deb_q >= DEB_LAST)
                obs_db_d = ~obs_db_q;
            else
                deb_d = deb_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (obs_db_q) begin
                    state_d = ALARM;
                    hold_d  = '0;
                end
            end
            ALARM: begin
                if (obs_db_q)
                    hold_d = '0;
                else if (hold_q >= HOLD_MAX)
                    state_d = RUN;
                else
                    hold_d = hold_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Stop wins over every other transition in the same cycle.
        if (stop) begin
            state_d = IDLE;
            hold_d  = '0;
        end
        cs_d = (state_q == ALARM) ? CS_ALARM :
               (state_q != RUN)   ? CS_STOP  :
               (tl_s == tr_s)     ? CS_FWD   :
               tl_s               ? CS_LEFT  : CS_RIGHT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            hold_q   <= '0;
            obs_db_q <= 1'b0;
            cs_q     <= CS_STOP;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            hold_q   <= hold_d;
            obs_db_q <= obs_db_d;
            cs_q     <= cs_d;
        end
    end
endmodule

// File: tb/tb_car_mode_ctrl.sv
// tb_car_mode_ctrl: vector table, directed corner sequences and random stimulus against a reference model.
module tb_car_mode_ctrl;
    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       obstacle = 1'b0, track_l = 1'b0, track_r = 1'b0, cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [2:0] cs;

    always #5 clk = ~clk;

    car_mode_ctrl #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .obstacle(obstacle), .track_l(track_l), .track_r(track_r),
        .cmd_valid(cmd_valid), .cmd(cmd), .cs(cs)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: mode as an integer, debounce as a disagreement run length,
    // synchronizers as a two-deep history queue of raw samples {obstacle, l, r}.
    int         m_mode;
    bit         m_db;
    int         m_run;
    int         m_hold;
    logic [2:0] m_cs;
    logic [2:0] hist[$];

    typedef struct {
        logic       cv;
        logic [1:0] c;
        logic       obs;
        logic       tl;
        logic       tr;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl[17];

    function automatic logic [2:0] steer(logic l, logic r);
        return (l == r) ? 3'b001 : (l ? 3'b011 : 3'b100);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_db = 0; m_run = 0; m_hold = 0; m_cs = 3'b000;
        hist = '{3'b000, 3'b000};
    endtask

    task automatic model_step();
        logic [2:0] s;
        int nm;
        s = hist[0];
        m_cs = (m_mode == 2) ? 3'b010 : (m_mode == 1) ? steer(s[1], s[0]) : 3'b000;
        nm = m_mode;
        if (m_mode == 0 && cmd_valid && cmd == 2'b01) nm = 1;
        else if (m_mode == 1 && m_db) begin nm = 2; m_hold = 0; end
        else if (m_mode == 2) begin
            if (m_db) m_hold = 0;
            else if (m_hold >= HOLD) nm = 1;
            else m_hold++;
        end
        if (cmd_valid && cmd == 2'b00) nm = 0;
        m_mode = nm;
        if (s[2] != m_db) begin
            m_run++;
            if (m_run == DEB) begin m_db = ~m_db; m_run = 0; end
        end else m_run = 0;
        void'(hist.pop_front());
        hist.push_back({obstacle, track_l, track_r});
    endtask

    task automatic check(string name, logic [2:0] exp);
        tests++;
        if (cs !== exp) begin
            fails++;
            $display("FAIL %s: cs=%b expected %b at %0t", name, cs, exp, $time);
        end
    endtask

    task automatic set_in(logic v, logic [1:0] c, logic o, logic l, logic r);
        cmd_valid = v; cmd = c; obstacle = o; track_l = l; track_r = r;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model", m_cs);
    endtask

    task automatic ticks_expect(int n, string name, logic [2:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check(name, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 2'b00, 0, 0, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset", 3'b000);
        rst = 1'b0;
    endtask

    task automatic start_run();
        set_in(1, 2'b01, 0, 0, 0);
        tick();
        check("start_edge", 3'b000);
        cmd_valid = 0;
        tick();
        check("run_fwd", 3'b001);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 2'b00, 0, 0, 0, 3'b000};
        tbl[1]  = '{1, 2'b01, 0, 0, 0, 3'b000};
        tbl[2]  = '{0, 2'b00, 0, 0, 0, 3'b001};
        tbl[3]  = '{0, 2'b00, 0, 1, 0, 3'b001};
        tbl[4]  = '{0, 2'b00, 0, 1, 0, 3'b001};
        tbl[5]  = '{0, 2'b00, 0, 1, 0, 3'b011};
        tbl[6]  = '{0, 2'b00, 0, 0, 1, 3'b011};
        tbl[7]  = '{0, 2'b00, 0, 0, 1, 3'b011};
        tbl[8]  = '{0, 2'b00, 0, 0, 1, 3'b100};
        tbl[9]  = '{0, 2'b00, 0, 1, 1, 3'b100};
        tbl[10] = '{0, 2'b00, 0, 1, 1, 3'b100};
        tbl[11] = '{0, 2'b00, 0, 1, 1, 3'b001};
        tbl[12] = '{1, 2'b10, 0, 1, 1, 3'b001};
        tbl[13] = '{1, 2'b01, 0, 1, 1, 3'b001};
        tbl[14] = '{1, 2'b00, 0, 1, 1, 3'b001};
        tbl[15] = '{1, 2'b11, 0, 1, 1, 3'b000};
        tbl[16] = '{0, 2'b00, 0, 1, 1, 3'b000};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].cv, tbl[i].c, tbl[i].obs, tbl[i].tl, tbl[i].tr);
            tick();
            check($sformatf("tbl[%0d]", i), tbl[i].exp);
        end

        // Short glitch is filtered, sustained obstacle alarms, then the hold releases.
        do_reset();
        start_run();
        obstacle = 1;
        ticks_expect(3, "glitch_hi", 3'b001);
        obstacle = 0;
        ticks_expect(10, "glitch_lo", 3'b001);
        obstacle = 1;
        ticks_expect(7, "pre_alarm", 3'b001);
        ticks_expect(1, "alarm", 3'b010);
        ticks_expect(3, "alarm_held", 3'b010);
        obstacle = 0;
        ticks_expect(17, "hold", 3'b010);
        ticks_expect(1, "resume", 3'b001);

        // Re-assertion with the hold counter at 6 restarts the whole hold.
        obstacle = 1;
        ticks_expect(7, "pre_alarm2", 3'b001);
        ticks_expect(3, "alarm2", 3'b010);
        obstacle = 0;
        ticks_expect(6, "hold_part", 3'b010);
        obstacle = 1;
        ticks_expect(10, "rehold", 3'b010);
        obstacle = 0;
        ticks_expect(17, "hold_full", 3'b010);
        ticks_expect(1, "resume2", 3'b001);

        // Stop together with obs_db rising: never shows alarm.
        do_reset();
        start_run();
        obstacle = 1;
        ticks_expect(6, "race_run", 3'b001);
        set_in(1, 2'b00, 1, 0, 0);
        ticks_expect(1, "race_stop", 3'b001);
        cmd_valid = 0;
        ticks_expect(10, "race_idle", 3'b000);

        // Asynchronous reset in alarm, then restart with obstacle still present.
        do_reset();
        start_run();
        obstacle = 1;
        ticks_expect(7, "pre_alarm3", 3'b001);
        ticks_expect(2, "alarm3", 3'b010);
        #2 rst = 1'b1;
        #1 check("async_rst", 3'b000);
        model_reset();
        @(negedge clk);
        check("rst_held", 3'b000);
        rst = 1'b0;
        ticks_expect(5, "post_rst_idle", 3'b000);
        set_in(1, 2'b01, 1, 0, 0);
        ticks_expect(1, "late_start", 3'b000);
        cmd_valid = 0;
        ticks_expect(1, "one_fwd", 3'b001);
        ticks_expect(1, "alarm_after_start", 3'b010);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 39) == 0);
            cmd       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) obstacle = ~obstacle;
            if ($urandom_range(0, 5) == 0) track_l = ~track_l;
            if ($urandom_range(0, 5) == 0) track_r = ~track_r;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
